// File: rtl/udp_rx_payload_packer_if.sv
// Packed-datagram output bus of udp_rx_payload_packer.
// master = packer (producer), slave = consumer.
interface udp_rx_payload_packer_if #(
  parameter int MAX_BYTES = 120
);
  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [MAX_BYTES*8-1:0] pkt_data;
  logic [15:0]            pkt_length;
  logic                   pkt_truncated;
  logic                   pkt_len_err;

  modport master (
    output pkt_valid,
    output pkt_data,
    output pkt_length,
    output pkt_truncated,
    output pkt_len_err,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid,
    input  pkt_data,
    input  pkt_length,
    input  pkt_truncated,
    input  pkt_len_err,
    output pkt_ready
  );
endinterface

// File: rtl/udp_rx_payload_packer.sv
// Collects one UDP payload burst into a right-aligned wide word and holds it
// until the consumer accepts it. Bursts that start while a datagram is still
// held are discarded and counted. MAX_BYTES must be at least 2.
module udp_rx_payload_packer #(
  parameter int MAX_BYTES = 120
) (
  input  logic                    rgmii_clk,
  input  logic                    rstn,
  input  logic                    udp_rec_data_valid,
  input  logic [7:0]              udp_rec_rdata,
  input  logic [15:0]             udp_rec_data_length,
  udp_rx_payload_packer_if.master pkt_if,
  output logic [15:0]             drop_cnt
);

  localparam int          W       = MAX_BYTES * 8;
  localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_OUT     = 2'd2;

  // Saturating 16-bit increment shared by the byte and drop counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  logic [1:0]   state_r;
  logic [15:0]  byte_cnt_r;
  logic [15:0]  hdr_len_r;
  logic [W-1:0] buf_r;
  logic         pkt_valid_r;
  logic [15:0]  pkt_length_r;
  logic         pkt_truncated_r;
  logic         pkt_len_err_r;
  logic [15:0]  drop_cnt_r;
  logic         drop_active_r;
  logic         valid_prev_r;

  logic         rise_s;
  logic         take_first_s;
  logic         drop_start_s;

  // Classify this cycle: burst start edge, accepted first byte, or start of a discarded burst.
  always_comb begin
    rise_s       = udp_rec_data_valid & ~valid_prev_r;
    take_first_s = 1'b0;
    drop_start_s = 1'b0;
    if (state_r == ST_IDLE) begin
      take_first_s = udp_rec_data_valid & ~drop_active_r;
    end else if (state_r == ST_OUT) begin
      drop_start_s = rise_s;
    end else begin
      take_first_s = 1'b0;
      drop_start_s = 1'b0;
    end
  end

  // Main FSM: load the first byte, shift in the rest, then hold the result until accepted.
  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      state_r         <= ST_IDLE;
      byte_cnt_r      <= 16'd0;
      hdr_len_r       <= 16'd0;
      buf_r           <= {W{1'b0}};
      pkt_valid_r     <= 1'b0;
      pkt_length_r    <= 16'd0;
      pkt_truncated_r <= 1'b0;
      pkt_len_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_first_s) begin
            // Buffer is cleared and the first byte lands in the low lane in one step.
            buf_r      <= {{(W-8){1'b0}}, udp_rec_rdata};
            byte_cnt_r <= 16'd1;
            hdr_len_r  <= udp_rec_data_length;
            state_r    <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (udp_rec_data_valid) begin
            // Bytes beyond capacity are counted but not stored.
            if (byte_cnt_r < MAX_LEN) begin
              buf_r <= {buf_r[W-9:0], udp_rec_rdata};
            end
            byte_cnt_r <= sat_inc16(byte_cnt_r);
          end else begin
            pkt_valid_r     <= 1'b1;
            pkt_length_r    <= byte_cnt_r;
            pkt_truncated_r <= (byte_cnt_r > MAX_LEN);
            pkt_len_err_r   <= (byte_cnt_r != hdr_len_r);
            state_r         <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (pkt_if.pkt_ready) begin
            pkt_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          pkt_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Track burst edges; a burst starting while a datagram is held is ignored to its end and counted.
  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      valid_prev_r  <= 1'b0;
      drop_active_r <= 1'b0;
      drop_cnt_r    <= 16'd0;
    end else begin
      valid_prev_r <= udp_rec_data_valid;
      if (!udp_rec_data_valid) begin
        drop_active_r <= 1'b0;
      end else if (drop_start_s) begin
        drop_active_r <= 1'b1;
      end else begin
        drop_active_r <= drop_active_r;
      end
      if (drop_start_s) begin
        drop_cnt_r <= sat_inc16(drop_cnt_r);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign pkt_if.pkt_valid     = pkt_valid_r;
  assign pkt_if.pkt_data      = buf_r;
  assign pkt_if.pkt_length    = pkt_length_r;
  assign pkt_if.pkt_truncated = pkt_truncated_r;
  assign pkt_if.pkt_len_err   = pkt_len_err_r;
  assign drop_cnt             = drop_cnt_r;

endmodule
